// File: rtl/dist_pkg.sv
// Shared types, widths and arithmetic helpers for the four-lane SAD distance block.
// Lanes and the top level import this so widths and saturation behaviour stay in one place.
package dist_pkg;

  localparam int DATA_WIDTH   = 16;
  localparam int FEAT_WIDTH   = 16;
  localparam int NUM_COEF_DEF = 13;
  localparam int NUM_LANES    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2,
    ERR   = 2'd3
  } dist_state_e;

  typedef logic [DATA_WIDTH-1:0]        dist_t;
  typedef logic signed [FEAT_WIDTH-1:0] feat_t;
  typedef logic [FEAT_WIDTH-1:0]        mag_t;

  function automatic dist_t sat_add(input dist_t a, input dist_t b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_WIDTH] ? '1 : s[DATA_WIDTH-1:0];
  endfunction

  // Difference taken one bit wider so the full signed range never overflows.
  function automatic mag_t abs_diff(input feat_t a, input feat_t b);
    logic [FEAT_WIDTH:0] d;
    logic [FEAT_WIDTH:0] n;
    d = {a[FEAT_WIDTH-1], a} - {b[FEAT_WIDTH-1], b};
    n = '0 - d;
    return d[FEAT_WIDTH] ? n[FEAT_WIDTH-1:0] : d[FEAT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/dist4_sad_accum_if.sv
// Beat/result bundle between the feature source, the SAD block and the minimum search.
// No backpressure: a beat is taken every cycle feat_valid is high; results are one-cycle strobes.
interface dist4_sad_accum_if;
  import dist_pkg::*;

  feat_t feat_data;
  feat_t tmpl_data_1;
  feat_t tmpl_data_2;
  feat_t tmpl_data_3;
  feat_t tmpl_data_4;
  logic  feat_valid;
  logic  feat_last;
  logic  frame_abort;

  dist_t distance_DATA_1;
  dist_t distance_DATA_2;
  dist_t distance_DATA_3;
  dist_t distance_DATA_4;
  logic  distance_EN_1;
  logic  distance_EN_2;
  logic  distance_EN_3;
  logic  distance_EN_4;
  logic  frame_err;

  modport master (
    output feat_data, tmpl_data_1, tmpl_data_2, tmpl_data_3, tmpl_data_4,
    output feat_valid, feat_last, frame_abort,
    input  distance_DATA_1, distance_DATA_2, distance_DATA_3, distance_DATA_4,
    input  distance_EN_1, distance_EN_2, distance_EN_3, distance_EN_4, frame_err
  );

  modport slave (
    input  feat_data, tmpl_data_1, tmpl_data_2, tmpl_data_3, tmpl_data_4,
    input  feat_valid, feat_last, frame_abort,
    output distance_DATA_1, distance_DATA_2, distance_DATA_3, distance_DATA_4,
    output distance_EN_1, distance_EN_2, distance_EN_3, distance_EN_4, frame_err
  );

endinterface

// File: rtl/dist4_sad_accum_sad_lane.sv
// One SAD lane: stage-1 absolute-difference register and stage-2 saturating accumulator.
// sum_o is the accumulator plus the registered term, used by the top to capture a final result.
module sad_lane
  import dist_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  feat_t feat_i,
  input  feat_t tmpl_i,
  input  logic  acc_load,
  input  logic  acc_add,
  input  logic  acc_clr,
  output dist_t sum_o
);

  mag_t  diff_d, diff_q;
  dist_t acc_d, acc_q;
  dist_t term;

  always_comb begin
    diff_d = abs_diff(feat_i, tmpl_i);
    term   = dist_t'(diff_q);
    sum_o  = sat_add(acc_q, term);
    acc_d  = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_load) begin
      acc_d = term;
    end else if (acc_add) begin
      acc_d = sum_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      acc_q  <= '0;
    end else begin
      diff_q <= diff_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/dist4_sad_accum.sv
// Four-template SAD accumulator: two-stage pipeline, frame-length checking FSM and result registers.
// A frame's last beat at cycle T shows up as distance_EN / frame_err at T+2.
module dist4_sad_accum
  import dist_pkg::*;
#(
  parameter int NUM_COEF = NUM_COEF_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  dist4_sad_accum_if.slave    bus,
  output dist_state_e         dbg_state,
  output logic [7:0]          dbg_coef_cnt
);

  // Stage 1 control: beat qualifier and last flag aligned with the lane difference registers.
  logic v1_d, v1_q;
  logic l1_d, l1_q;

  dist_state_e state_d, state_q;
  logic [7:0]  cnt_d, cnt_q;
  logic [8:0]  cnt_inc;
  logic        cnt_hit;
  logic        err_d, err_q;
  logic        acc_load, acc_add, acc_clr, emit_load;
  logic        en;

  feat_t tmpl_arr [NUM_LANES];
  dist_t lane_sum [NUM_LANES];
  dist_t dist_d   [NUM_LANES];
  dist_t dist_q   [NUM_LANES];

  assign tmpl_arr[0] = bus.tmpl_data_1;
  assign tmpl_arr[1] = bus.tmpl_data_2;
  assign tmpl_arr[2] = bus.tmpl_data_3;
  assign tmpl_arr[3] = bus.tmpl_data_4;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    sad_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .feat_i   (bus.feat_data),
      .tmpl_i   (tmpl_arr[k]),
      .acc_load (acc_load),
      .acc_add  (acc_add),
      .acc_clr  (acc_clr),
      .sum_o    (lane_sum[k])
    );
  end

  always_comb begin
    v1_d = bus.feat_valid & ~bus.frame_abort;
    l1_d = bus.feat_valid & bus.feat_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      l1_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      l1_q <= l1_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus lane, counter and result-capture controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    acc_clr   = 1'b0;
    emit_load = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = {1'b0, cnt_q} + 9'd1;
    cnt_hit   = (cnt_inc == 9'(NUM_COEF));
    if (bus.frame_abort) begin
      // The beat sitting in stage 1 belongs to the aborted frame and is dropped here.
      state_d = IDLE;
      cnt_d   = '0;
      acc_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, EMIT: begin
          state_d = IDLE;
          if (v1_q) begin
            acc_load = 1'b1;
            if (l1_q) begin
              err_d = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d   = 8'd1;
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (v1_q) begin
            acc_add = 1'b1;
            cnt_d   = cnt_inc[7:0];
            if (l1_q && cnt_hit) begin
              emit_load = 1'b1;
              cnt_d     = '0;
              state_d   = EMIT;
            end else if (l1_q) begin
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = IDLE;
            end else if (cnt_hit) begin
              // Frame ran long: flush until the source finally marks a last beat.
              err_d   = 1'b1;
              cnt_d   = '0;
              state_d = ERR;
            end
          end
        end
        ERR: begin
          if (v1_q && l1_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    en = (state_q == EMIT);
  end

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      dist_d[k] = emit_load ? lane_sum[k] : dist_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        dist_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        dist_q[k] <= dist_d[k];
      end
    end
  end

  assign bus.distance_DATA_1 = dist_q[0];
  assign bus.distance_DATA_2 = dist_q[1];
  assign bus.distance_DATA_3 = dist_q[2];
  assign bus.distance_DATA_4 = dist_q[3];
  assign bus.distance_EN_1   = en;
  assign bus.distance_EN_2   = en;
  assign bus.distance_EN_3   = en;
  assign bus.distance_EN_4   = en;
  assign bus.frame_err       = err_q;
  assign dbg_state           = state_q;
  assign dbg_coef_cnt        = cnt_q;

endmodule

// File: tb/tb_dist4_sad_accum.sv
// Bench for dist4_sad_accum: frame table, hand-written corner sequences and random frames,
// with expected strobes queued at drive time and matched by a negedge monitor.
module tb_dist4_sad_accum;
  import dist_pkg::*;

  localparam int NC = 13;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dist4_sad_accum_if bus ();
  dist_state_e dbg_state;
  logic [7:0]  dbg_coef_cnt;

  dist4_sad_accum #(.NUM_COEF(NC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_coef_cnt (dbg_coef_cnt)
  );

  typedef struct {
    int cyc;
    bit is_err;
    int d [4];
  } exp_t;

  typedef struct {
    int feat;
    int t [4];
    int nbeats;
    int last_at;
    int abort_at;
    int gap;
    bit exp_err;
    int err_at;
    int d [4];
  } vec_t;

  exp_t exp_q [$];
  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_fail = 0;
  int   last_d [4] = '{0, 0, 0, 0};
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_exp(input int c, input bit err, input int d0, input int d1,
                          input int d2, input int d3);
    exp_t e;
    e.cyc    = c;
    e.is_err = err;
    e.d[0] = d0; e.d[1] = d1; e.d[2] = d2; e.d[3] = d3;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int f, input int t0, input int t1, input int t2, input int t3,
                       input bit v, input bit l, input bit ab);
    @(posedge clk);
    #1;
    bus.feat_data   = feat_t'(f);
    bus.tmpl_data_1 = feat_t'(t0);
    bus.tmpl_data_2 = feat_t'(t1);
    bus.tmpl_data_3 = feat_t'(t2);
    bus.tmpl_data_4 = feat_t'(t3);
    bus.feat_valid  = v;
    bus.feat_last   = l;
    bus.frame_abort = ab;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data1"}, bus.distance_DATA_1, 0);
    check({tag, "_data2"}, bus.distance_DATA_2, 0);
    check({tag, "_data3"}, bus.distance_DATA_3, 0);
    check({tag, "_data4"}, bus.distance_DATA_4, 0);
    check({tag, "_en"}, {bus.distance_EN_1, bus.distance_EN_2, bus.distance_EN_3,
                         bus.distance_EN_4}, 0);
    check({tag, "_err"}, bus.frame_err, 0);
  endtask

  // Monitor: every strobe must match the head of the expected queue in cycle and content.
  always @(negedge clk) begin : monitor
    logic any_en;
    exp_t e;
    if (mon_en && rst_n) begin
      any_en = bus.distance_EN_1 | bus.distance_EN_2 | bus.distance_EN_3 | bus.distance_EN_4;
      if (any_en) begin
        check("en_identical", {bus.distance_EN_1, bus.distance_EN_2, bus.distance_EN_3,
                               bus.distance_EN_4}, 4'hF);
      end
      if (any_en || bus.frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {30'd0, any_en, bus.frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("frame_err", bus.frame_err, e.is_err);
          check("distance_en", any_en, !e.is_err);
          if (!e.is_err) begin
            check("distance1", bus.distance_DATA_1, e.d[0]);
            check("distance2", bus.distance_DATA_2, e.d[1]);
            check("distance3", bus.distance_DATA_3, e.d[2]);
            check("distance4", bus.distance_DATA_4, e.d[3]);
            last_d = e.d;
          end else begin
            check("held_distance1", bus.distance_DATA_1, last_d[0]);
            check("held_distance2", bus.distance_DATA_2, last_d[1]);
            check("held_distance3", bus.distance_DATA_3, last_d[2]);
            check("held_distance4", bus.distance_DATA_4, last_d[3]);
          end
        end
      end
    end
  end

  initial begin
    // feat, tmpl[4], nbeats, last_at, abort_at, gap, exp_err, err_at, expected distances
    vecs[0] = '{100, '{100, 90, -100, 110}, 13, 13, 0, 0, 1'b0, 0, '{0, 130, 2600, 130}};
    vecs[1] = '{-5, '{5, -5, 1000, -1000}, 13, 13, 0, 2, 1'b0, 0, '{130, 0, 13065, 12935}};
    vecs[2] = '{32767, '{-32768, -32768, 32000, 32767}, 13, 13, 0, 2, 1'b0, 0,
                '{65535, 65535, 9971, 0}};
    vecs[3] = '{1, '{2, 3, 4, 5}, 10, 10, 0, 1, 1'b1, 10, '{0, 0, 0, 0}};
    vecs[4] = '{1, '{2, 3, 4, 5}, 14, 14, 0, 0, 1'b1, 13, '{0, 0, 0, 0}};
    vecs[5] = '{7, '{0, 7, 14, -7}, 13, 13, 0, 3, 1'b0, 0, '{91, 0, 91, 182}};
    vecs[6] = '{9, '{1, 2, 3, 4}, 7, 0, 7, 0, 1'b0, 0, '{0, 0, 0, 0}};
    vecs[7] = '{-300, '{0, -300, 300, -32768}, 13, 13, 0, 2, 1'b0, 0,
                '{3900, 0, 7800, 65535}};
    vecs[8] = '{5, '{1, 1, 1, 1}, 1, 1, 0, 0, 1'b1, 1, '{0, 0, 0, 0}};
    vecs[9] = '{0, '{1, 2, 3, 4}, 13, 13, 0, 2, 1'b0, 0, '{13, 26, 39, 52}};

    bus.feat_data = '0; bus.tmpl_data_1 = '0; bus.tmpl_data_2 = '0;
    bus.tmpl_data_3 = '0; bus.tmpl_data_4 = '0;
    bus.feat_valid = 1'b0; bus.feat_last = 1'b0; bus.frame_abort = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    check("reset_state", dbg_state, IDLE);
    check("reset_coef_cnt", dbg_coef_cnt, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);

    for (int i = 0; i < NV; i++) begin
      for (int b = 1; b <= vecs[i].nbeats; b++) begin
        drive(vecs[i].feat, vecs[i].t[0], vecs[i].t[1], vecs[i].t[2], vecs[i].t[3],
              1'b1, b == vecs[i].last_at, b == vecs[i].abort_at);
        if (vecs[i].exp_err && b == vecs[i].err_at)
          push_exp(cyc + 2, 1'b1, 0, 0, 0, 0);
        if (!vecs[i].exp_err && b == vecs[i].last_at && vecs[i].abort_at == 0)
          push_exp(cyc + 2, 1'b0, vecs[i].d[0], vecs[i].d[1], vecs[i].d[2], vecs[i].d[3]);
      end
      idle(vecs[i].gap);
    end

    // Abort landing on the emit cycle must not cancel the already captured result.
    for (int b = 1; b <= NC; b++) begin
      drive(50, 0, 50, 60, -50, 1'b1, b == NC, 1'b0);
      if (b == NC) push_exp(cyc + 2, 1'b0, 650, 0, 130, 1300);
    end
    idle(1);
    drive(0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Reset in the middle of a frame: outputs clear at once, next frame is clean.
    for (int b = 1; b <= 4; b++) drive(3, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    drive(3, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.feat_valid = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    last_d = '{0, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int b = 1; b <= NC; b++) begin
      drive(1000, -1000, 0, 1000, 2000, 1'b1, b == NC, 1'b0);
      if (b == NC) push_exp(cyc + 2, 1'b0, 26000, 13000, 0, 13000);
    end
    idle(2);

    // Random frames against a reference sum clamped at the end (terms are never negative).
    for (int fr = 0; fr < 4; fr++) begin
      int s [4];
      s = '{0, 0, 0, 0};
      for (int b = 1; b <= NC; b++) begin
        logic signed [15:0] fv;
        logic signed [15:0] tv [4];
        int a;
        if (fr == 3) fv = ($urandom_range(0, 1) == 1) ? 16'sh7fff : 16'sh8000;
        else fv = 16'($urandom_range(0, 65535));
        for (int k = 0; k < 4; k++) begin
          tv[k] = 16'($urandom_range(0, 65535));
          a = int'(fv) - int'(tv[k]);
          if (a < 0) a = -a;
          s[k] += a;
        end
        drive(int'(fv), int'(tv[0]), int'(tv[1]), int'(tv[2]), int'(tv[3]),
              1'b1, b == NC, 1'b0);
      end
      for (int k = 0; k < 4; k++) if (s[k] > 65535) s[k] = 65535;
      push_exp(cyc + 2, 1'b0, s[0], s[1], s[2], s[3]);
      idle($urandom_range(0, 2));
    end

    idle(8);
    check("pending_strobes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
